// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Sits beside the ID stage and keeps a shadow copy of the destination-register
// state of the EX, MEM and WB stages: rd, write enable and, for EX, the
// load flag. From that state and the current ID operands it drives the P/Q
// forwarding selects, the control-unit bubble select, the PC and IF/ID load
// enables and the IF/ID flush. All outputs are combinational.
//
// Ports
//   clk          pipeline clock, state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   id_ra/id_rb  ID source registers (P / Q operands)
//   id_ra_used   ID instruction reads id_ra
//   id_rb_used   ID instruction reads id_rb
//   id_rd        ID target register
//   id_rf_le     ID instruction writes the register file
//   id_load      ID instruction is a memory load
//   ex_jump      jump taken by the instruction in EX
//   fw_p_sel     P forward select: 00 RF, 01 EX, 10 MEM, 11 WB
//   fw_q_sel     Q forward select, same encoding
//   cu_nop       bubble: zero control signals entering EX
//   pc_le        PC load enable
//   ifid_le      IF/ID register load enable
//   ifid_flush   clear IF/ID to nop on the next edge
//
// Optional feature, macro PIPE_HAZARD_PERF_EN:
//   stall_cnt    saturating count of cycles with a load-use stall applied
//   flush_cnt    saturating count of cycles with ifid_flush asserted
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_ra_used,
    input  logic       id_rb_used,
    input  logic [4:0] id_rd,
    input  logic       id_rf_le,
    input  logic       id_load,
    input  logic       ex_jump,
    output logic [1:0] fw_p_sel,
    output logic [1:0] fw_q_sel,
    output logic       cu_nop,
    output logic       pc_le,
    output logic       ifid_le,
    output logic       ifid_flush
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    // Shadow pipeline state
    logic [4:0] ex_rd_reg;
    logic       ex_we_reg;
    logic       ex_ld_reg;
    logic [4:0] mem_rd_reg;
    logic       mem_we_reg;
    logic [4:0] wb_rd_reg;
    logic       wb_we_reg;

    // A stage can forward only if it writes a register other than r0.
    logic ex_fwd;
    logic mem_fwd;
    logic wb_fwd;

    assign ex_fwd  = ex_we_reg  && (ex_rd_reg  != 5'd0);
    assign mem_fwd = mem_we_reg && (mem_rd_reg != 5'd0);
    assign wb_fwd  = wb_we_reg  && (wb_rd_reg  != 5'd0);

    // Operand 0 is P (id_ra), operand 1 is Q (id_rb).
    logic [4:0] src_reg_sel [2];
    logic [1:0] src_used;
    logic [1:0] sel_raw [2];
    logic [1:0] load_use_op;

    assign src_reg_sel[0] = id_ra;
    assign src_reg_sel[1] = id_rb;
    assign src_used       = {id_rb_used, id_ra_used};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic ex_hit;
            logic mem_hit;
            logic wb_hit;

            assign ex_hit  = src_used[gi] && ex_fwd  && (src_reg_sel[gi] == ex_rd_reg);
            assign mem_hit = src_used[gi] && mem_fwd && (src_reg_sel[gi] == mem_rd_reg);
            assign wb_hit  = src_used[gi] && wb_fwd  && (src_reg_sel[gi] == wb_rd_reg);

            // Youngest producer wins. A load still in EX has no data yet, so
            // its match becomes a load-use hazard instead of a forward; older
            // stages must not be used in that case because their value is stale.
            assign load_use_op[gi] = ex_hit && ex_ld_reg;
            assign sel_raw[gi]     = ex_hit  ? 2'b01 :
                                     mem_hit ? 2'b10 :
                                     wb_hit  ? 2'b11 : 2'b00;
        end
    endgenerate

    logic load_use;
    logic stall;

    assign load_use = |load_use_op;
    // A taken jump overrides the stall; it cannot coincide with a load-use
    // hazard architecturally, but the jump must never be lost.
    assign stall    = load_use && !ex_jump;

    always_comb begin
        fw_p_sel   = 2'b00;
        fw_q_sel   = 2'b00;
        cu_nop     = 1'b1;
        pc_le      = 1'b0;
        ifid_le    = 1'b0;
        ifid_flush = 1'b1;
        if (rst_n) begin
            fw_p_sel   = load_use ? 2'b00 : sel_raw[0];
            fw_q_sel   = load_use ? 2'b00 : sel_raw[1];
            cu_nop     = stall;
            pc_le      = !stall;
            ifid_le    = !stall;
            ifid_flush = ex_jump;
        end
    end

    // Shadow pipeline advance. A bubble enters EX with we=ld=0, so a stall
    // cannot retrigger on itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd_reg  <= 5'd0;
            ex_we_reg  <= 1'b0;
            ex_ld_reg  <= 1'b0;
            mem_rd_reg <= 5'd0;
            mem_we_reg <= 1'b0;
            wb_rd_reg  <= 5'd0;
            wb_we_reg  <= 1'b0;
        end else begin
            wb_rd_reg  <= mem_rd_reg;
            wb_we_reg  <= mem_we_reg;
            mem_rd_reg <= ex_rd_reg;
            mem_we_reg <= ex_we_reg;
            ex_rd_reg  <= id_rd;
            ex_we_reg  <= id_rf_le && !stall;
            ex_ld_reg  <= id_load  && !stall;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else begin
            if (stall && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (ex_jump && (flush_cnt_reg != 16'hFFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed scenarios with expected output words written out by hand, followed
// by a randomized run checked against a history model: the model keeps the
// last three issued instructions and derives each select from the distance to
// the youngest writer of the operand register.
// Output word layout: {fw_p_sel, fw_q_sel, cu_nop, pc_le, ifid_le, ifid_flush}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_ra;
    logic [4:0] id_rb;
    logic       id_ra_used;
    logic       id_rb_used;
    logic [4:0] id_rd;
    logic       id_rf_le;
    logic       id_load;
    logic       ex_jump;
    logic [1:0] fw_p_sel;
    logic [1:0] fw_q_sel;
    logic       cu_nop;
    logic       pc_le;
    logic       ifid_le;
    logic       ifid_flush;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] OUT_RST   = 8'b0000_1001;
    localparam logic [7:0] OUT_RUN   = 8'b0000_0110;
    localparam logic [7:0] OUT_STALL = 8'b0000_1000;
    localparam logic [7:0] OUT_JUMP  = 8'b0000_0111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_ra_used (id_ra_used),
        .id_rb_used (id_rb_used),
        .id_rd      (id_rd),
        .id_rf_le   (id_rf_le),
        .id_load    (id_load),
        .ex_jump    (ex_jump),
        .fw_p_sel   (fw_p_sel),
        .fw_q_sel   (fw_q_sel),
        .cu_nop     (cu_nop),
        .pc_le      (pc_le),
        .ifid_le    (ifid_le),
        .ifid_flush (ifid_flush)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    wire [7:0] outs = {fw_p_sel, fw_q_sel, cu_nop, pc_le, ifid_le, ifid_flush};

    task automatic set_in(input logic [4:0] ra, input logic [4:0] rb,
                          input logic ua, input logic ub,
                          input logic [4:0] rd, input logic we,
                          input logic ld, input logic j);
        id_ra      = ra;
        id_rb      = rb;
        id_ra_used = ua;
        id_rb_used = ub;
        id_rd      = rd;
        id_rf_le   = we;
        id_load    = ld;
        ex_jump    = j;
    endtask

    // Three non-writing instructions so no earlier writer stays visible.
    task automatic drain_pipe;
        repeat (3) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk);
            #1;
            checks++;
            if (outs !== OUT_RST) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b want %b", i, outs, OUT_RST);
            end
        end
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_in(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== OUT_RUN) begin
            errors++;
            $display("FAIL reset_release_add: got %b want %b", outs, OUT_RUN);
        end
        @(negedge clk);
    endtask

    task automatic test_ex_forward;
        drain_pipe();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 8'b0100_0110) begin
            errors++;
            $display("FAIL fwd_ex: got %b want %b", outs, 8'b0100_0110);
        end
        @(negedge clk);
        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 8'b0010_0110) begin
            errors++;
            $display("FAIL fwd_mem_q: got %b want %b", outs, 8'b0010_0110);
        end
        @(negedge clk);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 8'b1100_0110) begin
            errors++;
            $display("FAIL fwd_wb: got %b want %b", outs, 8'b1100_0110);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== OUT_RUN) begin
            errors++;
            $display("FAIL fwd_rf: got %b want %b", outs, OUT_RUN);
        end
        @(negedge clk);
    endtask

    task automatic test_priority_r0;
        drain_pipe();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        set_in(5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 8'b0101_0110) begin
            errors++;
            $display("FAIL prio_ex_over_mem: got %b want %b", outs, 8'b0101_0110);
        end
        @(negedge clk);
        drain_pipe();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== OUT_RUN) begin
            errors++;
            $display("FAIL r0_no_forward: got %b want %b", outs, OUT_RUN);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use;
        drain_pipe();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        // Reader of r4 that also writes r8; its first issue becomes the bubble.
        set_in(5'd8, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== OUT_STALL) begin
            errors++;
            $display("FAIL load_use_stall: got %b want %b", outs, OUT_STALL);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 8'b0010_0110) begin
            errors++;
            $display("FAIL load_use_after: got %b want %b", outs, 8'b0010_0110);
        end
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
        end
`endif
        @(negedge clk);
        set_in(5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 8'b0100_0110) begin
            errors++;
            $display("FAIL load_use_reissue_fwd: got %b want %b", outs, 8'b0100_0110);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [15:0] s0;
        drain_pipe();
`ifdef PIPE_HAZARD_PERF_EN
        s0 = stall_cnt;
`else
        s0 = 16'd0;
`endif
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_in(5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (outs !== OUT_STALL) begin
            errors++;
            $display("FAIL b2b_stall1: got %b want %b", outs, OUT_STALL);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 8'b1000_0110) begin
            errors++;
            $display("FAIL b2b_fwd1: got %b want %b", outs, 8'b1000_0110);
        end
        @(negedge clk);
        set_in(5'd0, 5'd11, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== OUT_STALL) begin
            errors++;
            $display("FAIL b2b_stall2: got %b want %b", outs, OUT_STALL);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== 8'b0010_0110) begin
            errors++;
            $display("FAIL b2b_fwd2: got %b want %b", outs, 8'b0010_0110);
        end
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== s0 + 16'd2) begin
            errors++;
            $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cnt, s0 + 16'd2);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_jump;
        logic [15:0] f0;
        logic [15:0] s0;
        drain_pipe();
`ifdef PIPE_HAZARD_PERF_EN
        f0 = flush_cnt;
`else
        f0 = 16'd0;
`endif
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (outs !== OUT_JUMP) begin
            errors++;
            $display("FAIL jump_flush: got %b want %b", outs, OUT_JUMP);
        end
        @(negedge clk);
        set_in(5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== 8'b0100_0110) begin
            errors++;
            $display("FAIL jump_delay_slot_we: got %b want %b", outs, 8'b0100_0110);
        end
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        if (flush_cnt !== f0 + 16'd1) begin
            errors++;
            $display("FAIL jump_flush_cnt: got %0d want %0d", flush_cnt, f0 + 16'd1);
        end
        s0 = stall_cnt;
`else
        s0 = 16'd0;
`endif
        @(negedge clk);
        drain_pipe();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_in(5'd0, 5'd13, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (outs !== OUT_JUMP) begin
            errors++;
            $display("FAIL jump_beats_load_use: got %b want %b", outs, OUT_JUMP);
        end
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== s0 || flush_cnt !== f0 + 16'd2) begin
            errors++;
            $display("FAIL jump_load_use_counts: got %0d/%0d want %0d/%0d",
                     stall_cnt, flush_cnt, s0, f0 + 16'd2);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_async_reset_mid_stall;
        drain_pipe();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        set_in(5'd14, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== OUT_STALL) begin
            errors++;
            $display("FAIL async_pre_stall: got %b want %b", outs, OUT_STALL);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== OUT_RST) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b want %b", outs, OUT_RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs !== OUT_RUN) begin
            errors++;
            $display("FAIL async_release_no_fwd: got %b want %b", outs, OUT_RUN);
        end
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_counters_cleared: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
    endtask

    // History model: index 1 is the most recently issued instruction (EX).
    logic [4:0] m_rd [1:3];
    logic       m_we [1:3];
    logic       m_ld [1:3];

    function automatic logic [1:0] dist_of(input logic [4:0] r);
        for (int d = 1; d <= 3; d++) begin
            if (r != 5'd0 && m_we[d] && m_rd[d] == r) return 2'(d);
        end
        return 2'd0;
    endfunction

    task automatic test_random;
        logic [4:0] ra, rb, rd;
        logic       ua, ub, we, ld, j, hz, st;
        logic [1:0] dp, dq;
        logic [7:0] want;
        int         exp_stall;
        int         exp_flush;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            m_rd[d] = 5'd0;
            m_we[d] = 1'b0;
            m_ld[d] = 1'b0;
        end
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 400; i++) begin
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            ua = 1'($urandom);
            ub = 1'($urandom);
            we = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 2) == 0);
            j  = ($urandom_range(0, 9) == 0);
            set_in(ra, rb, ua, ub, rd, we, ld, j);
            dp = ua ? dist_of(ra) : 2'd0;
            dq = ub ? dist_of(rb) : 2'd0;
            hz = m_ld[1] && (dp == 2'd1 || dq == 2'd1);
            st = hz && !j;
            want = {hz ? 2'd0 : dp, hz ? 2'd0 : dq, st, !st, !st, j};
            #1;
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", i, outs, want);
            end
            m_rd[3] = m_rd[2]; m_we[3] = m_we[2]; m_ld[3] = m_ld[2];
            m_rd[2] = m_rd[1]; m_we[2] = m_we[1]; m_ld[2] = m_ld[1];
            m_rd[1] = rd;      m_we[1] = we && !st; m_ld[1] = ld && !st;
            exp_stall += int'(st);
            exp_flush += int'(j);
            @(negedge clk);
        end
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
            errors++;
            $display("FAIL random_counters: got %0d/%0d want %0d/%0d",
                     stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_ex_forward();
        test_priority_r0();
        test_load_use();
        test_back_to_back();
        test_jump();
        test_async_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
